// File: rtl/arb_pkg.sv
// ============================================================================
// Module  : arb_pkg
// Purpose : Shared types, defaults and helpers for rr_priority_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int ARB_N    = 8;
    localparam int ARB_NMAX = 64;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Wide one-hot; callers size-cast the result down to their own N.
    function automatic logic [ARB_NMAX-1:0] onehot(input int unsigned id);
        return {{(ARB_NMAX-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational rotating-priority pick. The request vector is
//           rotated so ptr sits at the MSB, MSB-first encoded, then un-rotated.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] win_id
);

    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_enc_pos;

    // Rotated bit j holds req[(ptr + 1 + j) mod N], so bit N-1 is req[ptr].
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < N; j++) begin
            w_rot[j] = req[IDW'((int'(ptr) + 1 + j) % N)];
        end
    end

    always_comb begin
        w_enc_pos = '0;
        for (int j = 0; j < N; j++) begin
            if (w_rot[j]) begin
                w_enc_pos = IDW'(j);
            end
        end
    end

    assign any    = |req;
    assign win_id = IDW'((int'(w_enc_pos) + 1 + int'(ptr)) % N);

endmodule

`default_nettype wire

// File: rtl/rr_priority_arbiter.sv
// ============================================================================
// Module  : rr_priority_arbiter
// Purpose : Round-robin arbiter with locked grant, one-hot + binary grant ID.
//           Optional forced release after MAX_HOLD cycles: `define ARB_TIMEOUT_EN
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    localparam logic [IDW-1:0] c_ptr_rst = IDW'(N - 1);

    generate
        if (N < 2 || IDW != $clog2(N) || MAX_HOLD < 2) begin : g_bad_param
            $error("rr_priority_arbiter: illegal N/IDW/MAX_HOLD combination");
        end
    endgenerate

    arb_state_t     r_state, w_state_nxt;
    logic [IDW-1:0] r_ptr, w_ptr_nxt;
    logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt;
    logic [N-1:0]   r_gnt, w_gnt_nxt;
    logic           r_gnt_valid, w_gnt_valid_nxt;
    logic           w_any;
    logic [IDW-1:0] w_win_id;
    logic           w_rel_norm;
    logic           w_force;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .any    (w_any),
        .win_id (w_win_id)
    );

    // Only the current owner's lines matter; other done/req bits are ignored.
    assign w_rel_norm = done[r_gnt_id] | ~req[r_gnt_id];

`ifdef ARB_TIMEOUT_EN
    localparam int c_hold_w = $clog2(MAX_HOLD + 1);

    logic [c_hold_w-1:0] r_hold, w_hold_nxt;
    logic                r_timeout, w_timeout_nxt;

    assign w_force = (r_state == ARB_GRANT) && (r_hold == c_hold_w'(MAX_HOLD - 1));

    always_comb begin
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        if (r_state == ARB_IDLE) begin
            w_hold_nxt = '0;
        end else if (w_rel_norm || w_force) begin
            w_hold_nxt    = '0;
            w_timeout_nxt = w_force & ~w_rel_norm;
        end else begin
            w_hold_nxt = r_hold + c_hold_w'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_hold    <= w_hold_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt     = ARB_GRANT;
                    w_gnt_nxt       = N'(onehot(32'(w_win_id)));
                    w_gnt_id_nxt    = w_win_id;
                    w_gnt_valid_nxt = 1'b1;
                    // The winner drops to lowest priority for the next round.
                    w_ptr_nxt       = (w_win_id == '0) ? c_ptr_rst : w_win_id - IDW'(1);
                end
            end
            ARB_GRANT: begin
                if (w_rel_norm || w_force) begin
                    w_state_nxt     = ARB_IDLE;
                    w_gnt_nxt       = '0;
                    w_gnt_id_nxt    = '0;
                    w_gnt_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= c_ptr_rst;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
// ============================================================================
// Module  : tb_rr_priority_arbiter
// Purpose : Directed self-checking bench for rr_priority_arbiter (N=8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    rr_priority_arbiter #(
        .N        (8),
        .IDW      (3),
        .MAX_HOLD (16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_g(input string tag, input logic v, input int id);
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(v));
        chk({tag, ".gnt"}, 32'(gnt), v ? (32'd1 << id) : 32'd0);
        if (v) chk({tag, ".id"}, 32'(gnt_id), 32'(id));
        chk({tag, ".timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        int seq [8] = '{6, 5, 4, 3, 2, 1, 0, 7};
        int prev;

        // Reset with everyone requesting
        rst  = 1'b1;
        req  = 8'hFF;
        done = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_g("reset", 1'b0, 0);
        chk("reset.id", 32'(gnt_id), 32'd0);
        rst = 1'b0;
        step();
        chk_g("first", 1'b1, 7);

        // Full rotation with a dead cycle between grants
        prev = 7;
        for (int i = 0; i < 8; i++) begin
            done = 8'(32'd1 << prev);
            step();
            chk_g($sformatf("rot%0d.dead", i), 1'b0, 0);
            done = 8'h00;
            step();
            chk_g($sformatf("rot%0d.grant", i), 1'b1, seq[i]);
            prev = seq[i];
        end

        // Wrap: grant 0 leaves ptr at 7
        req  = 8'h01;
        done = 8'h80;
        step();
        chk_g("wrap.rel", 1'b0, 0);
        done = 8'h00;
        step();
        chk_g("wrap.g0", 1'b1, 0);
        req  = 8'h81;
        done = 8'h01;
        step();
        chk_g("wrap.rel0", 1'b0, 0);
        done = 8'h00;
        step();
        chk_g("wrap.g7", 1'b1, 7);
        done = 8'h80;
        step();
        chk_g("wrap.rel7", 1'b0, 0);
        done = 8'h00;
        step();
        chk_g("wrap.g0b", 1'b1, 0);

        // Lock: activity on index 5 must not disturb grant 3
        req  = 8'h08;
        done = 8'h01;
        step();
        chk_g("lock.rel", 1'b0, 0);
        done = 8'h00;
        step();
        chk_g("lock.g3", 1'b1, 3);
        req  = 8'h28;
        done = 8'h20;
        step();
        chk_g("lock.t1", 1'b1, 3);
        req  = 8'h08;
        done = 8'h00;
        step();
        chk_g("lock.t2", 1'b1, 3);
        req  = 8'h28;
        done = 8'h20;
        step();
        chk_g("lock.t3", 1'b1, 3);
        req  = 8'h20;
        done = 8'h00;
        step();
        chk_g("lock.drop", 1'b0, 0);
        step();
        chk_g("lock.g5", 1'b1, 5);
        req = 8'h00;
        step();
        chk_g("lock.rel5", 1'b0, 0);

        // Hold behaviour on requester 2
        req = 8'h04;
        step();
        chk_g("hold.g2", 1'b1, 2);
        req = 8'h44;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            step();
            chk_g($sformatf("hold.c%0d", i), 1'b1, 2);
        end
        step();
        chk("to.valid", 32'(gnt_valid), 32'd0);
        chk("to.pulse", 32'(timeout), 32'd1);
        chk("to.gnt", 32'(gnt), 32'd0);
        step();
        chk_g("to.g6", 1'b1, 6);
`else
        for (int i = 1; i < 21; i++) begin
            step();
            chk_g($sformatf("hold.c%0d", i), 1'b1, 2);
        end
`endif
        req = 8'h00;
        step();
        chk_g("hold.rel", 1'b0, 0);

        // Async reset in the middle of a grant
        req = 8'h81;
        step();
        chk_g("arst.g0", 1'b1, 0);
        #3;
        rst = 1'b1;
        #1;
        chk_g("arst.clr", 1'b0, 0);
        chk("arst.id", 32'(gnt_id), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk_g("arst.g7", 1'b1, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
